uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, meaning the clk_i frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115_200, meaning the line bit rate.
REQ-003 SHALL have parameter DEPTH, default 16, meaning the byte FIFO entry count (power of two, >=2).
REQ-004 clk_i  input  1  clock, all logic on posedge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 uart_val_i  input  1  upstream byte valid.
REQ-007 uart_data_i  input  8  upstream byte.
REQ-008 uart_rdy_o  output  1  byte accepted this cycle when uart_val_i is also high.
REQ-009 uart_avail_o  output  1  host present (flow control permits traffic).
REQ-010 uart_cts_ni  input  1  asynchronous clear-to-send from host, active-low.
REQ-011 uart_tx_o  output  1  serial line, idle high.

Function
REQ-012 SHALL compute DIV = (CLK_HZ + BAUD/2) / BAUD clocks per bit; DIV < 2 SHALL fail elaboration.
REQ-013 SHALL pass uart_cts_ni through a 2-flop synchronizer; cts_ok = synchronized value low.
REQ-014 uart_avail_o SHALL equal cts_ok, registered, with no extra qualification.
REQ-015 uart_rdy_o SHALL be high iff the FIFO is not full, independent of uart_val_i (no combinational val->rdy path).
REQ-016 On uart_val_i & uart_rdy_o the byte SHALL be written to the FIFO tail; order SHALL be preserved.
REQ-017 Bytes SHALL be accepted regardless of cts_ok; the FIFO absorbs them while the host is absent.
REQ-018 TX FSM states: IDLE, START, DATA, STOP.
REQ-019 IDLE: tx_o=1; if the FIFO is non-empty (registered count) and cts_ok, pop the head into the shift register and go to START.
REQ-020 START: tx_o=0 for DIV clocks, then DATA.
REQ-021 DATA: 8 bits LSB first, each held DIV clocks; after bit 7, go to STOP.
REQ-022 STOP: tx_o=1 for DIV clocks, then IDLE; back-to-back frames SHALL have exactly one IDLE cycle between stop and next start.
REQ-023 cts_ok deasserting mid-frame SHALL NOT abort the frame; it only blocks the next pop.
REQ-024 Latency: byte accepted at edge N into an empty FIFO with FSM IDLE and cts_ok -> pop at edge N+1, tx_o low from edge N+2.
REQ-025 Simultaneous push and pop SHALL both occur; count unchanged; a push into an empty FIFO SHALL NOT be popped in the same cycle.
REQ-026 FIFO pointers SHALL wrap modulo DEPTH; full = count==DEPTH, empty = count==0.
REQ-027 Bit counter width $clog2(DIV); bit index 3 bits; FIFO count $clog2(DEPTH)+1 bits.

Reset
REQ-028 Reset SHALL force: FSM IDLE, uart_tx_o=1, FIFO empty (uart_rdy_o=1), uart_avail_o=0, synchronizer flops 1 (cts_ok=0), counters 0.
REQ-029 Reset mid-frame SHALL drive tx_o high immediately and discard all queued bytes.

Structure
REQ-030 Package uart_pkg SHALL hold the tx_state_e enum (IDLE, START, DATA, STOP) and the frame constants (DATA_BITS=8, STOP_BITS=1).
REQ-031 The FIFO SHALL be a separate sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count).
REQ-032 Baud counter, synchronizer and FSM SHALL reside in uart_tx.

Verification (CLK_HZ=1_000_000, BAUD=250_000 -> DIV=4)
REQ-033 cts low, push 0x41 at edge 10 -> tx_o low at edges 12-15, then bits 1,0,0,0,0,0,1,0 at 4 clocks each, high from edge 48.
REQ-034 cts high, push 16 bytes -> rdy_o low after the 16th, tx_o stays 1; cts low -> all 16 emitted in order, 41 clocks apart.
REQ-035 cts raised during bit 3 of 0x55 -> frame completes intact; next byte not started until cts low plus 2-3 synchronizer cycles.
REQ-036 FIFO at count 15, push and pop the same cycle -> count stays 15, rdy_o stays 1, no byte lost or duplicated.
REQ-037 rst_ni pulsed low during DATA -> tx_o=1 asynchronously, rdy_o=1, avail_o=0, no residual bytes sent after release.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART transmitter slice.
//   tx_state_e : transmit FSM states (IDLE, START, DATA, STOP)
//   DATA_BITS  : payload bits per frame
//   STOP_BITS  : stop bits per frame
//   calc_div   : clocks per bit, rounded to nearest
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Round-to-nearest divider so that odd CLK_HZ/BAUD ratios do not bias the
  // bit period consistently short.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo -- single-clock FIFO with registered occupancy count.
//   clk_i   : clock, posedge
//   rst_ni  : asynchronous active-low reset (empties the FIFO)
//   push_i  : write wdata_i at the tail (ignored when full)
//   wdata_i : write data
//   pop_i   : drop the head entry (ignored when empty)
//   rdata_o : head entry, valid while not empty
//   full_o  : count == DEPTH
//   empty_o : count == 0
//   count_o : number of stored entries
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int             PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  // Pointers wrap by natural overflow, which needs a power-of-two depth.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem[rd_ptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Storage: data only, no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= wdata_i;
    end
  end

  // Control: pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx -- 8N1 UART transmitter with byte FIFO and CTS flow control.
//   clk_i        : clock, posedge
//   rst_ni       : asynchronous active-low reset
//   uart_val_i   : upstream byte valid
//   uart_data_i  : upstream byte
//   uart_rdy_o   : FIFO has room; byte taken when uart_val_i is also high
//   uart_avail_o : host present (synchronized CTS asserted), registered
//   uart_cts_ni  : asynchronous clear-to-send from host, active-low
//   uart_tx_o    : serial line, idle high, registered
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115_200,
  parameter int DEPTH  = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       uart_val_i,
  input  logic [7:0] uart_data_i,
  output logic       uart_rdy_o,
  output logic       uart_avail_o,
  input  logic       uart_cts_ni,
  output logic       uart_tx_o
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] DIV_M1    = CNT_W'(DIV - 1);
  localparam logic [2:0]       LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);

  if (DIV < 2) begin : g_div_chk
    $error("uart_tx: CLK_HZ/BAUD must give at least 2 clocks per bit");
  end

  // CTS synchronizer stage 0/1, then the registered availability flag.
  logic cts_meta_p0;
  logic cts_sync_p1;
  logic avail_p2;
  logic cts_ok;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cts_meta_p0 <= 1'b1;
      cts_sync_p1 <= 1'b1;
      avail_p2    <= 1'b0;
    end else begin
      cts_meta_p0 <= uart_cts_ni;
      cts_sync_p1 <= cts_meta_p0;
      avail_p2    <= ~cts_sync_p1;
    end
  end

  assign cts_ok       = ~cts_sync_p1;
  assign uart_avail_o = avail_p2;

  // Byte FIFO between the upstream handshake and the frame engine.
  logic [DATA_BITS-1:0]  fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                  pop;

  sync_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (uart_val_i),
    .wdata_i(uart_data_i),
    .pop_i  (pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  // Ready comes only from the registered count, never from uart_val_i.
  assign uart_rdy_o = ~fifo_full;

  // The FSM gates pops on the count; the flag decode must agree with it.
  a_empty_consistent : assert property (
    @(posedge clk_i) disable iff (!rst_ni) fifo_empty == (fifo_count == '0)
  );

  // Frame engine: state, baud counter, bit index, shift register.
  tx_state_e            state_q;
  tx_state_e            state_d;
  logic [CNT_W-1:0]     baud_cnt_q;
  logic [2:0]           bit_idx_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 tx_q;
  logic                 line_d;
  logic                 baud_last;

  assign baud_last = (baud_cnt_q == DIV_M1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // line_d is the line level belonging to the current state; it is
  // registered into tx_q, so the pin lags the state by one clock. That lag
  // is what puts the start bit two edges after the byte is accepted.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    line_d  = 1'b1;
    case (state_q)
      IDLE: begin
        // Only the registered count is consulted, so a byte pushed this
        // cycle into an empty FIFO is popped no earlier than next cycle.
        if ((fifo_count != '0) && cts_ok) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        line_d = 1'b0;
        if (baud_last) begin
          state_d = DATA;
        end
      end
      DATA: begin
        line_d = shreg_q[0];
        if (baud_last && (bit_idx_q == LAST_DATA)) begin
          state_d = STOP;
        end
      end
      STOP: begin
        // cts_ok is not examined mid-frame; it only blocks the next pop.
        if (baud_last && (bit_idx_q == LAST_STOP)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_q <= line_d;
      if (state_q == IDLE) begin
        baud_cnt_q <= '0;
        bit_idx_q  <= '0;
      end else begin
        baud_cnt_q <= baud_last ? '0 : baud_cnt_q + CNT_W'(1);
        // Bit index restarts at every state change so DATA and STOP each
        // count their own bits from zero.
        if (baud_last && (state_q != START)) begin
          bit_idx_q <= (state_d != state_q) ? 3'd0 : bit_idx_q + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (pop) begin
      shreg_q <= fifo_rdata;
    end else if ((state_q == DATA) && baud_last) begin
      shreg_q <= {1'b0, shreg_q[DATA_BITS-1:1]};
    end
  end

  assign uart_tx_o = tx_q;

endmodule
